cascade_scheduler: RTL and testbench
====================================

# cascade_scheduler

Shares the single LED cascade serializer between up to NUM_REQ independent pattern sources (sweep controller, status overlay, test pattern) so that each can request a frame without corrupting another's transmission. It grants one requester at a time in round-robin order and launches one cascade frame at that requester's LED position. It then enforces the mandatory latch (reset) gap on the strip before granting the next frame. It sits between the pattern FSMs and `generate_cascade`, replacing direct drive of `start_cascade`/`current_position`.

## Interface
- NUM_REQ, 3: number of requesters (≥2).
- NUM_LEDS, 51: LEDs on strip; legal positions 0..NUM_LEDS-1.
- POS_W, 6: position width, ≥ $clog2(NUM_LEDS).
- LATCH_CYCLES, 5000: strip latch gap in clk_in cycles (50 µs at 100 MHz).
- TIMEOUT_CYCLES, 200000: max cycles waiting for cascade completion.

- clk_in  in  1  system clock (100 MHz).
- rst_n_in  in  1  reset, asynchronous, active-low.
- req_in  in  NUM_REQ  per-requester frame request, level, held until done.
- pos_in  in  NUM_REQ*POS_W  per-requester position, slice i = requester i.
- grant_out  out  NUM_REQ  one-hot current owner, all-zero when none.
- done_out  out  NUM_REQ  one-cycle pulse to owner when its frame ends.
- error_out  out  1  one-cycle pulse on cascade timeout.
- start_cascade_out  out  1  one-cycle start pulse to serializer.
- current_position_out  out  POS_W  position driven to serializer.
- finished_cascade_in  in  1  serializer completion pulse.
- busy_out  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, TRANSMIT, LATCH.
- IDLE: if any req_in bit is high, pick winner = first set bit scanning upward (wrapping) from last_grant+1.
  - Register grant_out, last_grant, and current_position_out = min(pos_in[winner], NUM_LEDS-1).
  - Assert start_cascade_out for that one cycle and go to TRANSMIT.
- TRANSMIT: start_cascade_out=0; timeout counter increments each cycle.
  - On finished_cascade_in: done_out[winner]=1 for one cycle, grant_out←0, enter LATCH with latch counter=0.
  - If the counter reaches TIMEOUT_CYCLES first: error_out=1 and done_out[winner]=1 for one cycle, grant_out←0, enter LATCH.
- LATCH: stays exactly LATCH_CYCLES cycles, then IDLE. The latch counter is wide enough for LATCH_CYCLES; no wrap.
- current_position_out holds its value after grant until the next grant.
- pos_in is sampled only at grant; later changes are ignored for that frame.
- Requester dropping req_in mid-frame: the frame completes normally and done_out still pulses.
- finished_cascade_in outside TRANSMIT is ignored. A finish and a timeout in the same cycle count as a finish (no error).
- Reset values: state IDLE, grant_out 0, done_out 0, error_out 0, start_cascade_out 0, current_position_out 0, busy_out 0, last_grant NUM_REQ-1 (so requester 0 wins first), all counters 0.
- Reset asserted mid-frame: everything returns to reset values immediately. No done is issued.

## Timing
- Request-to-start latency: req_in rising at edge t in IDLE → grant_out and start_cascade_out high after edge t+1.
- Finish-to-done: finished_cascade_in at edge t → done_out pulse after edge t+1, same cycle as LATCH entry.
- Gap between done_out and the next start_cascade_out is exactly LATCH_CYCLES+1 cycles when a request is pending.
- A requester granted last cannot win again while any other req_in is high, which guarantees fairness.

## Test plan
- Single requester: req_in=3'b001, pos_in[0]=10; finish 100 cycles after start → grant 001, position 10, one start pulse, done_out=001 once, next start exactly 5001 cycles after done.
- Round-robin: req_in=3'b111 held; three frames granted in order 001, 010, 100, then 001 again.
- Clamp: pos_in[1]=60 with NUM_LEDS=51 → current_position_out=50.
- Timeout: serializer never finishes → error_out and done_out pulse after 200000 TRANSMIT cycles; LATCH follows; the next requester is granted.
- Mid-frame changes: pos_in[0] changed and req_in[0] dropped during TRANSMIT → position unchanged, done still pulses; finished_cascade_in in LATCH is ignored.
- Async reset: rst_n_in low mid-TRANSMIT, between clock edges → all outputs 0 without waiting for a clock edge. After release, requester 0 wins first.

Source files
------------

// File: rtl/cascade_scheduler.sv
// Round-robin arbiter that lends the single LED cascade serializer to one
// pattern source at a time, then holds the strip in its latch gap before the next frame.
module cascade_scheduler #(
  parameter int NUM_REQ        = 3,
  parameter int NUM_LEDS       = 51,
  parameter int POS_W          = 6,
  parameter int LATCH_CYCLES   = 5000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_REQ-1:0]       req_in,
  input  logic [NUM_REQ*POS_W-1:0] pos_in,
  output logic [NUM_REQ-1:0]       grant_out,
  output logic [NUM_REQ-1:0]       done_out,
  output logic                     error_out,
  output logic                     start_cascade_out,
  output logic [POS_W-1:0]         current_position_out,
  input  logic                     finished_cascade_in,
  output logic                     busy_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LT_W  = $clog2(LATCH_CYCLES + 1);
  localparam logic [POS_W-1:0]   MAX_POS     = POS_W'(NUM_LEDS - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]     NUM_REQ_EXT = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, TRANSMIT, LATCH} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  last_grant;
  logic [TO_W-1:0]   to_cnt;
  logic [LT_W-1:0]   lt_cnt;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W:0]    scan_sum;
  logic [POS_W-1:0]  pos_sel;
  logic [POS_W-1:0]  pos_clamped;
  logic [NUM_REQ-1:0] grant_next;

  logic launch, finish_evt, timeout_evt, frame_end, latch_done;

  // Winner is the first requesting index after last_grant, wrapping, so the
  // previous owner is always considered last.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_sum = {1'b0, last_grant} + (IDX_W + 1)'(k);
      if (scan_sum >= NUM_REQ_EXT) scan_sum = scan_sum - NUM_REQ_EXT;
      if (!pick_valid && req_in[scan_sum[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    pos_sel    = '0;
    grant_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pos_sel       = pos_in[i*POS_W +: POS_W];
        grant_next[i] = 1'b1;
      end
    end
    pos_clamped = (pos_sel > MAX_POS) ? MAX_POS : pos_sel;
  end

  // A finish arriving on the timeout cycle wins, so no error is reported then.
  assign launch      = (state == IDLE) && pick_valid;
  assign finish_evt  = (state == TRANSMIT) && finished_cascade_in;
  assign timeout_evt = (state == TRANSMIT) && !finished_cascade_in &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign frame_end   = finish_evt || timeout_evt;
  assign latch_done  = (state == LATCH) && (lt_cnt == LT_W'(LATCH_CYCLES - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (launch)     state_next = TRANSMIT;
      TRANSMIT: if (frame_end)  state_next = LATCH;
      LATCH:    if (latch_done) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_out = (state != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      grant_out            <= '0;
      done_out             <= '0;
      error_out            <= 1'b0;
      start_cascade_out    <= 1'b0;
      current_position_out <= '0;
      last_grant           <= LAST_IDX;
      to_cnt               <= '0;
      lt_cnt               <= '0;
    end else begin
      start_cascade_out <= launch;
      error_out         <= timeout_evt;
      done_out          <= frame_end ? grant_out : '0;

      // Position is captured only here and held until the next grant.
      if (launch) begin
        grant_out            <= grant_next;
        last_grant           <= pick_idx;
        current_position_out <= pos_clamped;
      end else if (frame_end) begin
        grant_out <= '0;
      end

      to_cnt <= (state == TRANSMIT) ? to_cnt + 1'b1 : '0;
      lt_cnt <= (state == LATCH)    ? lt_cnt + 1'b1 : '0;
    end
  end

  a_grant_onehot: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    $onehot0(grant_out));
  a_start_owned: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    start_cascade_out |-> (state == TRANSMIT) && (grant_out != '0));

endmodule

// File: tb/tb_cascade_scheduler.sv
// Directed bench for cascade_scheduler: a timeline-based reference model compared every
// cycle, plus hand-computed latency, ordering, clamp, timeout and reset expectations.
module tb_cascade_scheduler;

  localparam int NUM_REQ = 3;
  localparam int NUM_LEDS = 51;
  localparam int POS_W = 6;
  localparam int L = 40;
  localparam int T = 300;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*POS_W-1:0] pos = '0;
  logic                     finished = 1'b0;
  logic [NUM_REQ-1:0]       grant, done;
  logic                     error, start, busy;
  logic [POS_W-1:0]         cur_pos;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  cascade_scheduler #(
    .NUM_REQ(NUM_REQ), .NUM_LEDS(NUM_LEDS), .POS_W(POS_W),
    .LATCH_CYCLES(L), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .pos_in(pos),
    .grant_out(grant), .done_out(done), .error_out(error),
    .start_cascade_out(start), .current_position_out(cur_pos),
    .finished_cascade_in(finished), .busy_out(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (timeline of edges) ----------------
  int m_edge = 0;     // count of non-reset rising edges
  int m_owner = -1;   // requester whose frame is on the strip, -1 when none
  int m_last = NUM_REQ - 1;
  int m_t0 = 0;       // edge at which the current frame was launched
  int m_free = 0;     // first edge at which a new grant may happen
  int m_win;
  logic [NUM_REQ-1:0] e_grant = '0, e_done = '0;
  logic [POS_W-1:0]   e_pos = '0;
  logic               e_start = 1'b0, e_err = 1'b0, e_busy = 1'b0;

  function automatic int pick_winner(input logic [NUM_REQ-1:0] r, input int last);
    int res;
    res = -1;
    for (int k = 1; k <= NUM_REQ; k++)
      if (res < 0 && r[(last + k) % NUM_REQ]) res = (last + k) % NUM_REQ;
    return res;
  endfunction

  function automatic logic [POS_W-1:0] clamp(input logic [POS_W-1:0] p);
    return (int'(p) > NUM_LEDS - 1) ? POS_W'(NUM_LEDS - 1) : p;
  endfunction

  always_comb m_win = pick_winner(req, m_last);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1; m_last <= NUM_REQ - 1; m_free <= 0; m_t0 <= 0;
      e_grant <= '0; e_done <= '0; e_pos <= '0;
      e_start <= 1'b0; e_err <= 1'b0; e_busy <= 1'b0;
    end else begin
      m_edge  <= m_edge + 1;
      e_start <= 1'b0; e_done <= '0; e_err <= 1'b0;
      if (m_owner >= 0) begin
        e_busy <= 1'b1;
        if (finished || (m_edge - m_t0 == T)) begin
          e_done  <= NUM_REQ'(1 << m_owner);
          e_err   <= !finished;
          e_grant <= '0;
          m_owner <= -1;
          m_free  <= m_edge + L + 1;
        end
      end else if (m_edge >= m_free && m_win >= 0) begin
        m_owner <= m_win; m_last <= m_win; m_t0 <= m_edge;
        e_grant <= NUM_REQ'(1 << m_win);
        e_pos   <= clamp(pos[m_win*POS_W +: POS_W]);
        e_start <= 1'b1;
        e_busy  <= 1'b1;
      end else begin
        e_busy <= (m_edge + 1 < m_free);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_grant", 32'(grant), 32'(e_grant));
      check("cyc_done", 32'(done), 32'(e_done));
      check("cyc_error", 32'(error), 32'(e_err));
      check("cyc_start", 32'(start), 32'(e_start));
      check("cyc_pos", 32'(cur_pos), 32'(e_pos));
      check("cyc_busy", 32'(busy), 32'(e_busy));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string name, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!start && n < budget);
    check(name, 32'(start), 32'd1);
  endtask

  task automatic pulse_finish;
    finished = 1'b1;
    tick();
    finished = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < L + T + 20) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  logic [NUM_REQ-1:0] rr_grant [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [POS_W-1:0]   rr_pos   [4] = '{6'd0, 6'd50, 6'd50, 6'd0};

  initial begin
    int n;
    tick(); tick();
    cmp_en = 1'b1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pos", 32'(cur_pos), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single requester: latency, position, done, latch gap
    req = 3'b001;
    pos[0 +: POS_W] = 6'd10;
    wait_start("t1_start", 20, n);
    check("t1_latency", 32'(n), 32'd1);
    check("t1_grant", 32'(grant), 32'b001);
    check("t1_pos", 32'(cur_pos), 32'd10);
    repeat (100) tick();
    pulse_finish();
    check("t1_done", 32'(done), 32'b001);
    check("t1_error", 32'(error), 32'd0);
    wait_start("t1_restart", L + 20, n);
    check("t1_gap", 32'(n), 32'(L + 1));
    req = '0;
    pulse_finish();
    wait_idle("t1_idle");

    // Round-robin order from reset, with clamping of positions 60 and 63
    do_reset();
    pos = {6'd63, 6'd60, 6'd0};
    req = 3'b111;
    for (int f = 0; f < 4; f++) begin
      wait_start("rr_start", L + 20, n);
      check("rr_grant", 32'(grant), 32'(rr_grant[f]));
      check("rr_pos", 32'(cur_pos), 32'(rr_pos[f]));
      repeat (5) tick();
      pulse_finish();
    end
    req = '0;
    wait_idle("rr_idle");

    // Timeout: requester 1 wins (last grant was 0), serializer never finishes
    req = 3'b011;
    wait_start("to_start", 20, n);
    check("to_grant", 32'(grant), 32'b010);
    n = 0;
    do begin
      tick();
      n++;
    end while (!error && n < T + 20);
    check("to_cycles", 32'(n), 32'(T));
    check("to_done", 32'(done), 32'b010);
    wait_start("to_next", L + 20, n);
    check("to_gap", 32'(n), 32'(L + 1));
    check("to_next_grant", 32'(grant), 32'b001);
    req = '0;
    pulse_finish();
    wait_idle("to_idle");

    // Mid-frame changes; finish lands on the timeout edge; finish during LATCH ignored
    req = 3'b001;
    pos[0 +: POS_W] = 6'd7;
    wait_start("mf_start", L + 20, n);
    pos[0 +: POS_W] = 6'd33;
    req = '0;
    repeat (T - 1) tick();
    check("mf_pos_held", 32'(cur_pos), 32'd7);
    pulse_finish();
    check("mf_done", 32'(done), 32'b001);
    check("mf_no_error", 32'(error), 32'd0);
    repeat (3) tick();
    pulse_finish();
    check("latch_fin_done", 32'(done), 32'd0);
    check("latch_fin_busy", 32'(busy), 32'd1);
    wait_idle("mf_idle");

    // Asynchronous reset between edges in TRANSMIT
    req = 3'b001;
    pos[0 +: POS_W] = 6'd12;
    wait_start("ar_start", 20, n);
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_grant", 32'(grant), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_pos", 32'(cur_pos), 32'd0);
    check("ar_start_out", 32'(start), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    req = 3'b011;
    wait_start("ar_restart", 20, n);
    check("ar_latency", 32'(n), 32'd1);
    check("ar_first_grant", 32'(grant), 32'b001);
    req = '0;
    pulse_finish();
    wait_idle("ar_idle");

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
